// File: rtl/ddc_rx_1bit.sv
// ddc_rx_1bit: 1-bit direct-downconversion receiver (quadrature square-wave NCO, order-2 CIC, valid/ready out).
// Optional cross-product FM discriminator enabled by defining FMRX_DISCRIM_EN.
`default_nettype none

module ddc_rx_1bit #(
  parameter logic [31:0] CARRIER = 32'd2439541424,
  parameter int          DECIM   = 3125,
  parameter int          CIC_W   = 26,
  parameter int          OUT_W   = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    rf_i,
  input  logic                    ready_i,
  output logic                    valid_o,
  output logic signed [OUT_W-1:0] i_o,
  output logic signed [OUT_W-1:0] q_o,
  output logic signed [OUT_W-1:0] audio_o,
  output logic                    ovf_o,
  output logic                    led_o
);

  localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int SHIFT = CIC_W - OUT_W;
  localparam logic signed [CIC_W-1:0] PLUS_ONE  = CIC_W'(1);
  localparam logic signed [CIC_W-1:0] MINUS_ONE = '1;

  logic                    rf_meta, rf_s;
  logic [31:0]             ph;
  logic                    mix_i_neg, mix_q_neg;
  logic signed [CIC_W-1:0] step_i, step_q;
  logic signed [CIC_W-1:0] int1_i, int2_i, int1_q, int2_q;
  logic signed [CIC_W-1:0] dly1_i, dly2_i, dly1_q, dly2_q;
  logic signed [CIC_W-1:0] comb1_i, comb2_i, comb1_q, comb2_q;
  logic [CNT_W-1:0]        dcnt;
  logic                    tick;
  logic                    a_valid, b_valid;
  logic signed [OUT_W-1:0] a_i, a_q, b_i, b_q, b_audio, audio_next;
  logic [11:0]             sample_cnt;

  // Mixing by a +/-1 LO is just an XOR of sign bits; rf_s=0 means x=-1.
  always_comb begin
    mix_i_neg = ~rf_s ^ (ph[31] ^ ph[30]);
    mix_q_neg = ~rf_s ^ ph[31];
    step_i    = mix_i_neg ? MINUS_ONE : PLUS_ONE;
    step_q    = mix_q_neg ? MINUS_ONE : PLUS_ONE;
    tick      = (dcnt == CNT_W'(DECIM - 1));
    comb1_i   = int2_i - dly1_i;
    comb2_i   = comb1_i - dly2_i;
    comb1_q   = int2_q - dly1_q;
    comb2_q   = comb1_q - dly2_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_meta <= 1'b0;
      rf_s    <= 1'b0;
      ph      <= '0;
      int1_i  <= '0;
      int2_i  <= '0;
      int1_q  <= '0;
      int2_q  <= '0;
      dcnt    <= '0;
    end else begin
      rf_meta <= rf_i;
      rf_s    <= rf_meta;
      ph      <= ph + CARRIER;
      int1_i  <= int1_i + step_i;
      int2_i  <= int2_i + int1_i;
      int1_q  <= int1_q + step_q;
      int2_q  <= int2_q + int1_q;
      dcnt    <= tick ? '0 : dcnt + CNT_W'(1);
    end
  end

  // Stage A: comb section at decimated rate, truncated to the output width.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dly1_i  <= '0;
      dly2_i  <= '0;
      dly1_q  <= '0;
      dly2_q  <= '0;
      a_i     <= '0;
      a_q     <= '0;
      a_valid <= 1'b0;
    end else begin
      a_valid <= tick;
      if (tick) begin
        dly1_i <= int2_i;
        dly2_i <= comb1_i;
        dly1_q <= int2_q;
        dly2_q <= comb1_q;
        a_i    <= OUT_W'(comb2_i >>> SHIFT);
        a_q    <= OUT_W'(comb2_q >>> SHIFT);
      end
    end
  end

`ifdef FMRX_DISCRIM_EN
  logic signed [OUT_W-1:0]  i_prev, q_prev;
  logic signed [2*OUT_W:0]  ip_x, qp_x, ia_x, qa_x, disc;

  always_comb begin
    ip_x = (2*OUT_W+1)'(i_prev);
    qp_x = (2*OUT_W+1)'(q_prev);
    ia_x = (2*OUT_W+1)'(a_i);
    qa_x = (2*OUT_W+1)'(a_q);
    disc = ip_x * qa_x - qp_x * ia_x;
    audio_next = OUT_W'(disc >>> OUT_W);
    if (disc[2*OUT_W] != disc[2*OUT_W-1])
      audio_next = disc[2*OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      i_prev <= '0;
      q_prev <= '0;
    end else if (a_valid) begin
      i_prev <= a_i;
      q_prev <= a_q;
    end
  end
`else
  always_comb begin
    audio_next = '0;
  end
`endif

  // Stage B keeps I/Q latency identical whether or not the discriminator exists.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      b_valid <= 1'b0;
      b_i     <= '0;
      b_q     <= '0;
      b_audio <= '0;
    end else begin
      b_valid <= a_valid;
      if (a_valid) begin
        b_i     <= a_i;
        b_q     <= a_q;
        b_audio <= audio_next;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o    <= 1'b0;
      i_o        <= '0;
      q_o        <= '0;
      audio_o    <= '0;
      ovf_o      <= 1'b0;
      led_o      <= 1'b0;
      sample_cnt <= '0;
    end else if (b_valid) begin
      sample_cnt <= sample_cnt + 12'd1;
      if (sample_cnt == 12'hFFF)
        led_o <= ~led_o;
      // A pending unaccepted sample wins; the new one is dropped.
      if (valid_o && !ready_i) begin
        ovf_o <= 1'b1;
      end else begin
        valid_o <= 1'b1;
        i_o     <= b_i;
        q_o     <= b_q;
        audio_o <= b_audio;
      end
    end else if (valid_o && ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ddc_rx_1bit.sv
// tb_ddc_rx_1bit: table-driven and hand-sequenced checks of ddc_rx_1bit with a sample scoreboard.
`default_nettype none

module tb_ddc_rx_1bit;

  localparam logic [31:0] CARRIER = 32'd2439541424;
  localparam logic [31:0] TONE    = 32'd171799;
  localparam int          DECIM   = 3125;
  localparam int          LAT     = 3127;
  localparam int          FS      = 9536;
  localparam int          TIMEOUT = 4000;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic rf_i = 1'b0;
  logic ready_i = 1'b1;
  logic valid_o, ovf_o, led_o;
  logic signed [15:0] i_o, q_o, audio_o;

  ddc_rx_1bit dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .rf_i(rf_i), .ready_i(ready_i),
    .valid_o(valid_o), .i_o(i_o), .q_o(q_o), .audio_o(audio_o),
    .ovf_o(ovf_o), .led_o(led_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int mode;
    int exp_i;
    int tol_i;
    int exp_q;
    int tol_q;
  } vec_t;

  vec_t vecs[4];
  vec_t sb[$];
  int   total = 0;
  int   passed = 0;
  int   mode = 0;

  // RF source: model LO phase tracks the DUT NCO; rf_i leads by the 2-flop synchroniser.
  initial begin
    logic [31:0] mph, toff, nph;
    mph  = '0;
    toff = '0;
    forever begin
      @(posedge clk_i);
      if (!rst_ni) begin
        mph  = '0;
        toff = '0;
      end else begin
        mph  = mph + CARRIER;
        toff = toff + TONE;
      end
      #1;
      nph = mph + 2 * CARRIER;
      case (mode)
        1: rf_i = ~(nph[31] ^ nph[30]);
        2: rf_i = ~nph[31];
        3: rf_i = nph[31];
        4: begin nph = nph + toff + 2 * TONE; rf_i = ~(nph[31] ^ nph[30]); end
        5: begin nph = nph - toff - 2 * TONE; rf_i = ~(nph[31] ^ nph[30]); end
        default: rf_i = 1'b0;
      endcase
    end
  end

  task automatic check(input string name, input int act, input int exp, input int tol);
    total++;
    if (act >= exp - tol && act <= exp + tol) passed++;
    else $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, tol);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(posedge clk_i);
      #1;
      n++;
    end while (!valid_o && n < TIMEOUT);
    if (!valid_o) begin
      total++;
      $display("FAIL valid_timeout: got no valid_o, expected one within %0d clocks", TIMEOUT);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Asserts reset between clock edges and checks the outputs clear immediately.
  task automatic assert_reset();
    @(posedge clk_i);
    #3;
    rst_ni = 1'b0;
    #1;
    check("rst_valid", int'(valid_o), 0, 0);
    check("rst_i", int'(i_o), 0, 0);
    check("rst_q", int'(q_o), 0, 0);
    check("rst_audio", int'(audio_o), 0, 0);
    check("rst_ovf", int'(ovf_o), 0, 0);
    check("rst_led", int'(led_o), 0, 0);
    @(negedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic release_reset();
    int lat;
    rst_ni = 1'b1;
    wait_valid(lat);
    check("first_latency", lat, LAT, 0);
  endtask

  initial begin
    int n, held_i, held_q;
    vec_t e;
    // Tuning word is ~71/125 cycle/clock, so each square LO carries a 1/125 DC term:
    // the quiet channel settles near +/-77 rather than 0.
    vecs[0] = '{0, 0,   80, 0,   80};
    vecs[1] = '{1, FS,  4,  0,   80};
    vecs[2] = '{2, 0,   80, FS,  4};
    vecs[3] = '{3, 0,   80, -FS, 4};

    for (int v = 0; v < 4; v++) begin
      mode    = vecs[v].mode;
      ready_i = 1'b1;
      assert_reset();
      release_reset();
      sb.push_back(vecs[v]);
      wait_valid(n);
      wait_valid(n);
      check("period", n, DECIM, 0);
      e = sb.pop_front();
      check($sformatf("i_mode%0d", e.mode), int'(i_o), e.exp_i, e.tol_i);
      check($sformatf("q_mode%0d", e.mode), int'(q_o), e.exp_q, e.tol_q);
`ifndef FMRX_DISCRIM_EN
      check($sformatf("audio_mode%0d", e.mode), int'(audio_o), 0, 0);
`endif
    end

    // Backpressure across two loads: first held, second dropped, overflow sticky.
    mode    = 1;
    ready_i = 1'b0;
    assert_reset();
    release_reset();
    held_i = int'(i_o);
    held_q = int'(q_o);
    clocks(DECIM - 1);
    check("ovf_before_drop", int'(ovf_o), 0, 0);
    clocks(1);
    check("held_valid", int'(valid_o), 1, 0);
    check("held_i", int'(i_o), held_i, 0);
    check("held_q", int'(q_o), held_q, 0);
    check("ovf_after_drop", int'(ovf_o), 1, 0);
    ready_i = 1'b1;
    clocks(1);
    check("accept_clears_valid", int'(valid_o), 0, 0);
    check("ovf_sticky", int'(ovf_o), 1, 0);

    // Mid-sample reset clears everything, including the sticky overflow.
    clocks(1000);
    ready_i = 1'b0;
    assert_reset();
    release_reset();

    // Handshake landing on the load cycle: both samples delivered, no overflow.
    held_i = int'(i_o);
    clocks(DECIM - 1);
    ready_i = 1'b1;
    clocks(1);
    check("same_cycle_valid", int'(valid_o), 1, 0);
    check("same_cycle_ovf", int'(ovf_o), 0, 0);
    check("same_cycle_new", int'(int'(i_o) != held_i), 1, 0);
    clocks(1);
    check("same_cycle_accept", int'(valid_o), 0, 0);
    check("same_cycle_ovf_after", int'(ovf_o), 0, 0);

`ifdef FMRX_DISCRIM_EN
    begin
      int ap, am;
      mode = 4;
      assert_reset();
      release_reset();
      repeat (3) wait_valid(n);
      ap   = int'(audio_o);
      mode = 5;
      assert_reset();
      release_reset();
      repeat (3) wait_valid(n);
      am   = int'(audio_o);
      check("tone_opposite_sign", int'((ap > 0 && am < 0) || (ap < 0 && am > 0)), 1, 0);
    end
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
